tt_mux_ctrl: RTL and testbench
==============================

Name: tt_mux_ctrl

Overview:
- Project-select controller for the multiplexed user-project array.
- A host writes a project address serially over three slow pins. The block then runs a break-before-make switch: isolate all projects, enable the chosen one, hold it in reset for a fixed time, then release it.
- Drives the pin mux select plus per-project enable and reset lines. Exactly one project is live at a time, or none.

Parameters:
- N_PROJ, 24, number of selectable projects; valid addresses are 0..N_PROJ-1.
- ADDR_W, 5, address width; 2^ADDR_W must be >= N_PROJ.
- RST_CYCLES, 4, clk cycles the selected project's reset is held low (>= 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ctrl_sclk  input  1  serial shift clock from pad, asynchronous to clk.
- ctrl_data  input  1  serial address bit from pad, sampled on the synchronised sclk rising edge.
- ctrl_load  input  1  load strobe from pad, asynchronous; rising edge commits the address.
- proj_ena  output  N_PROJ  one-hot project enable; all zero when no project is selected.
- proj_rst_n  output  N_PROJ  per-project active-low reset.
- mux_sel  output  ADDR_W  select index for the pin mux.
- mux_valid  output  1  pin mux may drive outputs; low means the mux outputs are forced to zero.
- busy  output  1  switch sequence in progress.
- err  output  1  sticky flag: last load carried an invalid address.

Behaviour:
- Reset values: proj_ena=0, proj_rst_n=all 0, mux_sel=0, mux_valid=0, busy=0, err=0, shift register=0, state=OFF.
- Pin synchronisation:
  - Each of ctrl_sclk, ctrl_data and ctrl_load passes through a 2-flop synchroniser.
  - sclk and load then feed a rising-edge detector.
  - An internal 1-cycle pulse appears 3 clk cycles after the pin edge (±1 cycle for sampling phase).
- Shifting:
  - On an sclk pulse: shreg <= {shreg[ADDR_W-2:0], data_sync}. The address is sent MSB first.
  - Shifting is allowed in every state and never disturbs the live selection.
- Load pulse at cycle T:
  - If shreg < N_PROJ: target <= shreg, err <= 0, and the FSM enters ISOLATE at T+1.
  - Otherwise: err <= 1 and the FSM enters OFF at T+1. All outputs return to their reset values except err.
  - A load wins over everything else. A load arriving in ISOLATE or RESET restarts the sequence from ISOLATE with the new target.
  - A load of the currently running address re-resets that project (full sequence).
  - If sclk and load pulse in the same cycle, the load uses shreg from before the shift.
- FSM states:
  - OFF: proj_ena=0, proj_rst_n=0, mux_valid=0, busy=0.
  - ISOLATE (1 cycle): same outputs as OFF but busy=1; mux_sel <= target.
  - RESET (RST_CYCLES cycles, down-counter):
    - proj_ena[target]=1, proj_rst_n all 0, mux_valid=0, busy=1.
    - Transitions to RUN when the counter reaches 0.
  - RUN: proj_ena[target]=1, proj_rst_n[target]=1, mux_valid=1, busy=0. Stays in RUN until the next load.
- Timing:
  - Load pulse at T: ISOLATE at T+1, RESET at T+2..T+1+RST_CYCLES, RUN from T+2+RST_CYCLES.
  - Break-before-make: no cycle ever has two bits of proj_ena set.
  - mux_valid is never high while proj_rst_n[mux_sel] is low.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Asserting rst_n mid-sequence forces OFF immediately. The shift register is cleared.

Decomposition:
- Package tt_mux_pkg holds:
  - the state enum (OFF, ISOLATE, RESET, RUN);
  - default parameter constants;
  - an ADDR_W-bit address typedef.
- Sub-module tt_mux_pin_sync: 2-flop synchroniser plus registered rising-edge pulse, with outputs level and pulse. It is instantiated three times; for ctrl_data only the level output is used.

Test Plan:
- Reset release, no pin activity for 50 cycles -> proj_ena=0, proj_rst_n=0, mux_valid=0, busy=0, err=0.
- Shift 5'b00011 (MSB first), then pulse load -> busy for 1+4 cycles, then proj_ena=24'h000008, proj_rst_n[3]=1 with all other bits 0, mux_sel=3, mux_valid=1.
- Running project 3, load 17 -> one ISOLATE cycle with proj_ena=0, 4 RESET cycles with proj_ena[17]=1 and proj_rst_n[17]=0, then RUN on 17; never two enable bits set.
- Load 30 (invalid) while running project 17 -> next cycle OFF with all outputs cleared and err=1; a following valid load of 5 -> err=0 and RUN on project 5.
- Load 9, then load 2 while in RESET -> sequence restarts at ISOLATE; project 9 is never released from reset; final state RUN on project 2.
- Assert rst_n low during RESET for project 6 -> outputs cleared within the same cycle; after release the state is OFF and the shift register is 0.

Source files
------------

// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared definitions for the project-select controller.
//   state_e        : switch-sequence states (OFF, ISOLATE, RESET, RUN)
//   *_DEF          : default parameter values for tt_mux_ctrl
//   addr_t         : project address at the default address width
package tt_mux_pkg;

  localparam int N_PROJ_DEF     = 24;
  localparam int ADDR_W_DEF     = 5;
  localparam int RST_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/tt_mux_pin_sync.sv
// tt_mux_pin_sync: brings one asynchronous pad signal into the clk domain.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin_i      : raw pad input, asynchronous to clk
//   level_o    : synchronised level (2-flop synchroniser output)
//   pulse_o    : registered 1-cycle pulse on a synchronised rising edge,
//                high 3 clk edges after the pad edge is first captured
module tt_mux_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign level_o = sync_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl: project-select controller for the multiplexed project array.
// A host shifts a project address in MSB first on ctrl_sclk/ctrl_data and
// commits it with a ctrl_load rising edge. A valid address runs a
// break-before-make switch: ISOLATE (everything off, 1 cycle), RESET (new
// project enabled but held in reset for RST_CYCLES cycles), RUN (released,
// pin mux enabled). An invalid address turns everything off and sets err.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   ctrl_sclk   : serial shift clock from pad (async)
//   ctrl_data   : serial address bit from pad (async)
//   ctrl_load   : load strobe from pad (async), rising edge commits address
//   proj_ena    : one-hot project enable, zero when nothing is selected
//   proj_rst_n  : per-project active-low reset
//   mux_sel     : pin mux select index
//   mux_valid   : pin mux may drive outputs
//   busy        : switch sequence in progress
//   err         : last load carried an out-of-range address (sticky)
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ     = N_PROJ_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_sclk,
  input  logic              ctrl_data,
  input  logic              ctrl_load,
  output logic [N_PROJ-1:0] proj_ena,
  output logic [N_PROJ-1:0] proj_rst_n,
  output logic [ADDR_W-1:0] mux_sel,
  output logic              mux_valid,
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W    = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]   N_LIM    = (ADDR_W + 1)'(N_PROJ);

  // Synchronised pad signals
  logic sclk_pulse;
  logic load_pulse;
  logic data_level;
  logic sclk_level_unused;
  logic load_level_unused;
  logic data_pulse_unused;

  tt_mux_pin_sync u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ctrl_sclk),
    .level_o (sclk_level_unused),
    .pulse_o (sclk_pulse)
  );

  tt_mux_pin_sync u_sync_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ctrl_data),
    .level_o (data_level),
    .pulse_o (data_pulse_unused)
  );

  tt_mux_pin_sync u_sync_load (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ctrl_load),
    .level_o (load_level_unused),
    .pulse_o (load_pulse)
  );

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < N_LIM);
  endfunction

  // Decode by comparison so an address beyond N_PROJ never indexes out of range.
  function automatic logic [N_PROJ-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [N_PROJ-1:0] v;
    v = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (idx == ADDR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Address shift register. The FSM reads shreg_q, so a load landing in the
  // same cycle as a shift sees the value from before that shift.
  logic [ADDR_W-1:0] shreg_q;
  logic [ADDR_W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (sclk_pulse) shreg_d = {shreg_q[ADDR_W-2:0], data_level};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shreg_q <= '0;
    else        shreg_q <= shreg_d;
  end

  // Switch sequencer with registered outputs: each transition writes the
  // output values of the state being entered.
  state_e            state_q;
  logic [ADDR_W-1:0] target_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_PROJ-1:0] proj_ena_q;
  logic [N_PROJ-1:0] proj_rst_n_q;
  logic [ADDR_W-1:0] mux_sel_q;
  logic              mux_valid_q;
  logic              busy_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      target_q     <= '0;
      cnt_q        <= '0;
      proj_ena_q   <= '0;
      proj_rst_n_q <= '0;
      mux_sel_q    <= '0;
      mux_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (load_pulse) begin
      // A load preempts any state; everything is isolated first.
      proj_ena_q   <= '0;
      proj_rst_n_q <= '0;
      mux_valid_q  <= 1'b0;
      cnt_q        <= '0;
      if (addr_ok(shreg_q)) begin
        state_q   <= ST_ISOLATE;
        target_q  <= shreg_q;
        mux_sel_q <= shreg_q;
        busy_q    <= 1'b1;
        err_q     <= 1'b0;
      end else begin
        state_q   <= ST_OFF;
        mux_sel_q <= '0;
        busy_q    <= 1'b0;
        err_q     <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_ISOLATE: begin
          state_q    <= ST_RESET;
          cnt_q      <= CNT_LOAD;
          proj_ena_q <= onehot(target_q);
        end
        ST_RESET: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RUN;
            proj_rst_n_q <= onehot(target_q);
            mux_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // OFF and RUN hold until the next load.
        end
      endcase
    end
  end

  assign proj_ena   = proj_ena_q;
  assign proj_rst_n = proj_rst_n_q;
  assign mux_sel    = mux_sel_q;
  assign mux_valid  = mux_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl. Two instances share the pads: one with the default
// 4-cycle reset hold and one with a 32-cycle hold, long enough for a second
// address to be shifted in and loaded while the first project is in RESET.
// The reference model records when each load takes effect and derives every
// output from the number of cycles elapsed since then.
module tb_tt_mux_ctrl;
  import tt_mux_pkg::*;

  localparam int NP      = 24;
  localparam int AW      = 5;
  localparam int R_SHORT = 4;
  localparam int R_LONG  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ctrl_sclk = 1'b0;
  logic ctrl_data = 1'b0;
  logic ctrl_load = 1'b0;

  logic [NP-1:0] ena_s, rstn_s, ena_l, rstn_l;
  logic [AW-1:0] sel_s, sel_l;
  logic          valid_s, busy_s, err_s, valid_l, busy_l, err_l;

  always #5 clk = ~clk;

  tt_mux_ctrl #(.N_PROJ(NP), .ADDR_W(AW), .RST_CYCLES(R_SHORT)) dut_s (
    .clk(clk), .rst_n(rst_n), .ctrl_sclk(ctrl_sclk), .ctrl_data(ctrl_data),
    .ctrl_load(ctrl_load), .proj_ena(ena_s), .proj_rst_n(rstn_s),
    .mux_sel(sel_s), .mux_valid(valid_s), .busy(busy_s), .err(err_s)
  );

  tt_mux_ctrl #(.N_PROJ(NP), .ADDR_W(AW), .RST_CYCLES(R_LONG)) dut_l (
    .clk(clk), .rst_n(rst_n), .ctrl_sclk(ctrl_sclk), .ctrl_data(ctrl_data),
    .ctrl_load(ctrl_load), .proj_ena(ena_l), .proj_rst_n(rstn_l),
    .mux_sel(sel_l), .mux_valid(valid_l), .busy(busy_l), .err(err_l)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Reference model state
  bit m_on;        // a valid selection is active (sequence or running)
  int m_t0;        // clock edge at which the selection took effect
  int m_tgt;
  int m_sel;
  bit m_err;
  int m_shreg;     // address the host has shifted in
  bit pend;        // load pin raised, not yet taken effect
  int pend_edge;
  int pend_addr;
  bit watch9;
  bit seen9_rel;

  function automatic logic [55:0] expect_vec(int r);
    logic [NP-1:0] e, rn;
    logic v, b;
    int d;
    e = '0; rn = '0; v = 1'b0; b = 1'b0;
    if (m_on) begin
      d = edge_n - m_t0;
      if (d == 0) begin
        b = 1'b1;
      end else if (d <= r) begin
        e[m_tgt] = 1'b1;
        b = 1'b1;
      end else begin
        e[m_tgt]  = 1'b1;
        rn[m_tgt] = 1'b1;
        v = 1'b1;
      end
    end
    return {e, rn, AW'(m_sel), v, b, m_err};
  endfunction

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %014h expected %014h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_cycle();
    chk("outs_short", {ena_s, rstn_s, sel_s, valid_s, busy_s, err_s}, expect_vec(R_SHORT));
    chk("outs_long",  {ena_l, rstn_l, sel_l, valid_l, busy_l, err_l}, expect_vec(R_LONG));
    chk("bbm_short", 56'($countones(ena_s) <= 1), 56'd1);
    chk("bbm_long",  56'($countones(ena_l) <= 1), 56'd1);
    chk("mvld_short", 56'(!(valid_s && !rstn_s[sel_s])), 56'd1);
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_err = 1'b0; m_sel = 0; m_tgt = 0; m_t0 = 0;
    m_shreg = 0; pend = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (pend && edge_n == pend_edge) begin
      pend = 1'b0;
      if (pend_addr < NP) begin
        m_on = 1'b1; m_t0 = edge_n; m_tgt = pend_addr; m_sel = pend_addr; m_err = 1'b0;
      end else begin
        m_on = 1'b0; m_sel = 0; m_err = 1'b1;
      end
    end
    @(negedge clk);
    if (watch9 && rstn_l[9]) seen9_rel = 1'b1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Data is held one cycle either side of the sclk high phase so the
  // synchronised data level is settled when the shift pulse arrives.
  task automatic shift_bit(input bit b);
    ctrl_data = b;
    tick();
    ctrl_sclk = 1'b1;
    tick(); tick();
    ctrl_sclk = 1'b0;
    tick();
    m_shreg = ((m_shreg << 1) | int'(b)) & ((1 << AW) - 1);
  endtask

  task automatic shift_addr(input int a);
    for (int k = AW - 1; k >= 0; k--) shift_bit(a[k]);
  endtask

  // Load pin raised before edge edge_n+1: 2 synchroniser edges, the pulse
  // register edge, then the controller acts on edge edge_n+4.
  task automatic do_load();
    pend_addr = m_shreg;
    pend_edge = edge_n + 4;
    pend = 1'b1;
    ctrl_load = 1'b1;
    tick(); tick(); tick();
    ctrl_load = 1'b0;
  endtask

  initial begin
    model_reset();
    watch9 = 1'b0;
    seen9_rel = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    chk("idle_state", {ena_s, rstn_s, valid_s, busy_s, err_s}, 56'd0);

    // Select project 3
    shift_addr(3);
    do_load();
    idle(10);
    chk("run3_ena",  56'(ena_s),  56'h000008);
    chk("run3_rstn", 56'(rstn_s), 56'h000008);
    chk("run3_sel",  56'(sel_s),  56'd3);
    chk("run3_mvld", 56'({valid_s, busy_s}), 56'b10);

    // Switch 3 -> 17
    shift_addr(17);
    do_load();
    idle(10);
    chk("run17_ena", 56'(ena_s), 56'h020000);
    chk("run17_sel", 56'(sel_s), 56'd17);
    idle(30);

    // Invalid address 30, then valid 5
    shift_addr(30);
    do_load();
    idle(4);
    chk("bad30", {ena_s, rstn_s, sel_s, valid_s, busy_s, err_s}, 56'd1);
    shift_addr(5);
    do_load();
    idle(10);
    chk("run5_err", 56'(err_s), 56'd0);
    chk("run5_ena", 56'(ena_s), 56'h000020);
    idle(40);

    // Load 9, then 2 while the long instance still holds 9 in reset
    shift_addr(9);
    do_load();
    watch9 = 1'b1;
    shift_addr(2);
    do_load();
    idle(45);
    watch9 = 1'b0;
    chk("p9_never_released", 56'(seen9_rel), 56'd0);
    chk("run2_long_ena", 56'(ena_l), 56'h000004);
    chk("run2_long_rstn", 56'(rstn_l), 56'h000004);

    // Reload the running address: full re-reset of project 2
    do_load();
    idle(3);
    chk("rerst2_rstn", 56'(rstn_s), 56'h000000);
    idle(40);

    // Asynchronous reset during RESET of project 6
    shift_addr(6);
    do_load();
    idle(2);
    chk("p6_in_reset", 56'({ena_s[6], rstn_s[6], busy_s}), 56'b101);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_s", {ena_s, rstn_s, sel_s, valid_s, busy_s, err_s}, 56'd0);
    chk("async_rst_l", {ena_l, rstn_l, sel_l, valid_l, busy_l, err_l}, 56'd0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    // A load with nothing shifted selects project 0, showing shreg was cleared.
    do_load();
    idle(40);
    chk("shreg_cleared", 56'(ena_l), 56'h000001);

    // Randomised loads with random gaps
    for (int n = 0; n < 10; n++) begin
      shift_addr(int'($urandom_range(0, 31)));
      do_load();
      idle(int'($urandom_range(3, 45)));
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
